// File: rtl/rename_arbiter.sv
// Arbitrates rename requesters onto the single register-file request port and routes each
// response back to its owner. Define RENAME_ARB_RR_EN for round-robin; otherwise fixed priority 0 > 1 > 2.
module rename_arbiter #(
    parameter int NREQ       = 3,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                register_flush,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ-1:0]     req_simple,
    input  logic [NREQ-1:0]     req_bos,
    input  logic [NREQ-1:0]     req_op1_flag,
    input  logic [NREQ-1:0]     req_op2_flag,
    input  logic [NREQ*4-1:0]   req_id,
    input  logic [NREQ*5-1:0]   req_rd,
    input  logic [NREQ*5-1:0]   req_rs1,
    input  logic [NREQ*5-1:0]   req_rs2,
    output logic                rename_need,
    output logic                rename_need_ins_is_simple,
    output logic                rename_need_ins_is_branch_or_store,
    output logic                operand_1_flag,
    output logic                operand_2_flag,
    output logic [3:0]          rename_need_id,
    output logic [3:0]          new_ins_rd_rename,
    output logic [4:0]          new_ins_rd,
    output logic [4:0]          operand_1_reg,
    output logic [4:0]          operand_2_reg,
    input  logic                rename_finish,
    input  logic                simple_ins_commit,
    input  logic [3:0]          rename_finish_id,
    output logic [NREQ-1:0]     done,
    output logic [3:0]          done_id,
    output logic                resp_err
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [IW-1:0] q_owner  [FIFO_DEPTH];
    logic          q_simple [FIFO_DEPTH];
    logic [3:0]    q_id     [FIFO_DEPTH];
    logic          q_aged   [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic active;
    logic q_full;
    logic q_empty;
    assign active  = rdy && !register_flush;
    assign q_full  = (count == CW'(FIFO_DEPTH));
    assign q_empty = (count == '0);

    logic [IW-1:0] arb_start;
`ifdef RENAME_ARB_RR_EN
    logic [IW-1:0] rr_ptr;
    assign arb_start = rr_ptr;
`else
    assign arb_start = '0;
`endif

    logic          grant_any;
    logic [IW-1:0] grant_idx;
    logic [IW-1:0] cand;

    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int off = 0; off < NREQ; off++) begin
            cand = IW'((int'(arb_start) + off) % NREQ);
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    logic xfer;
    assign xfer = active && !q_full && grant_any;

    always_comb begin
        req_ready = '0;
        if (xfer) req_ready[grant_idx] = 1'b1;
    end

    logic [3:0] win_id;
    logic [4:0] win_rd;
    logic [4:0] win_rs1;
    logic [4:0] win_rs2;
    assign win_id  = req_id[int'(grant_idx)*4 +: 4];
    assign win_rd  = req_rd[int'(grant_idx)*5 +: 5];
    assign win_rs1 = req_rs1[int'(grant_idx)*5 +: 5];
    assign win_rs2 = req_rs2[int'(grant_idx)*5 +: 5];

    // A response must match the head's kind exactly; a head that has seen one edge without a response is stale.
    logic resp_any;
    logic head_match;
    logic pop;
    assign resp_any   = rename_finish || simple_ins_commit;
    assign head_match = q_simple[rd_ptr] ? (simple_ins_commit && !rename_finish)
                                         : (rename_finish && !simple_ins_commit);
    assign pop        = active && !q_empty && (resp_any || q_aged[rd_ptr]);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rename_need                        <= 1'b0;
            rename_need_ins_is_simple          <= 1'b0;
            rename_need_ins_is_branch_or_store <= 1'b0;
            operand_1_flag                     <= 1'b0;
            operand_2_flag                     <= 1'b0;
            rename_need_id                     <= '0;
            new_ins_rd_rename                  <= '0;
            new_ins_rd                         <= '0;
            operand_1_reg                      <= '0;
            operand_2_reg                      <= '0;
            done                               <= '0;
            done_id                            <= '0;
            resp_err                           <= 1'b0;
            wr_ptr                             <= '0;
            rd_ptr                             <= '0;
            count                              <= '0;
`ifdef RENAME_ARB_RR_EN
            rr_ptr                             <= '0;
`endif
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                q_owner[i]  <= '0;
                q_simple[i] <= 1'b0;
                q_id[i]     <= '0;
                q_aged[i]   <= 1'b0;
            end
        end else if (rdy) begin
            if (register_flush) begin
                rename_need <= 1'b0;
                done        <= '0;
                wr_ptr      <= '0;
                rd_ptr      <= '0;
                count       <= '0;
            end else begin
                rename_need <= xfer;
                done        <= '0;
                if (resp_any && q_empty) resp_err <= 1'b1;
                if (pop) begin
                    if (resp_any && head_match) begin
                        done[q_owner[rd_ptr]] <= 1'b1;
                        done_id               <= rename_finish ? rename_finish_id : q_id[rd_ptr];
                    end else begin
                        resp_err <= 1'b1;
                    end
                    rd_ptr <= ptr_inc(rd_ptr);
                end
                for (int i = 0; i < FIFO_DEPTH; i++) q_aged[i] <= 1'b1;
                if (xfer) begin
                    rename_need_ins_is_simple          <= req_simple[grant_idx];
                    rename_need_ins_is_branch_or_store <= req_bos[grant_idx];
                    operand_1_flag                     <= req_op1_flag[grant_idx];
                    operand_2_flag                     <= req_op2_flag[grant_idx];
                    rename_need_id                     <= win_id;
                    new_ins_rd_rename                  <= win_id;
                    new_ins_rd                         <= win_rd;
                    operand_1_reg                      <= win_rs1;
                    operand_2_reg                      <= win_rs2;
                    q_owner[wr_ptr]                    <= grant_idx;
                    q_simple[wr_ptr]                   <= req_simple[grant_idx];
                    q_id[wr_ptr]                       <= win_id;
                    q_aged[wr_ptr]                     <= 1'b0;
                    wr_ptr                             <= ptr_inc(wr_ptr);
`ifdef RENAME_ARB_RR_EN
                    rr_ptr <= (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
`endif
                end
                count <= count + CW'(xfer) - CW'(pop);
            end
        end
    end

endmodule

// File: tb/tb_rename_arbiter.sv
// Randomized self-checking bench for rename_arbiter against a queue-based reference model.
// Honours RENAME_ARB_RR_EN the same way as the design.
module tb_rename_arbiter;
    localparam int NREQ  = 3;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        register_flush;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [2:0]  req_simple, req_bos, req_op1_flag, req_op2_flag;
    logic [11:0] req_id;
    logic [14:0] req_rd, req_rs1, req_rs2;
    logic        rename_need, rename_need_ins_is_simple, rename_need_ins_is_branch_or_store;
    logic        operand_1_flag, operand_2_flag;
    logic [3:0]  rename_need_id, new_ins_rd_rename;
    logic [4:0]  new_ins_rd, operand_1_reg, operand_2_reg;
    logic        rename_finish, simple_ins_commit;
    logic [3:0]  rename_finish_id;
    logic [2:0]  done;
    logic [3:0]  done_id;
    logic        resp_err;

    always #5 clk = ~clk;

    rename_arbiter #(.NREQ(NREQ), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .register_flush(register_flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_simple(req_simple), .req_bos(req_bos),
        .req_op1_flag(req_op1_flag), .req_op2_flag(req_op2_flag),
        .req_id(req_id), .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .rename_need(rename_need), .rename_need_ins_is_simple(rename_need_ins_is_simple),
        .rename_need_ins_is_branch_or_store(rename_need_ins_is_branch_or_store),
        .operand_1_flag(operand_1_flag), .operand_2_flag(operand_2_flag),
        .rename_need_id(rename_need_id), .new_ins_rd_rename(new_ins_rd_rename),
        .new_ins_rd(new_ins_rd), .operand_1_reg(operand_1_reg), .operand_2_reg(operand_2_reg),
        .rename_finish(rename_finish), .simple_ins_commit(simple_ins_commit),
        .rename_finish_id(rename_finish_id),
        .done(done), .done_id(done_id), .resp_err(resp_err)
    );

    typedef struct {
        int       owner;
        bit       simple;
        bit [3:0] id;
        int       age;
    } entry_t;

    entry_t   mq[$];
    bit       mErr, mNeed, mSimple, mBos, mOp1, mOp2;
    bit [3:0] mId, mDoneId;
    bit [4:0] mRd, mRs1, mRs2;
    bit [2:0] mDone;
    int       mNext;

    bit       pend[NREQ];
    bit       pSimple[NREQ], pBos[NREQ], pOp1[NREQ], pOp2[NREQ];
    bit [3:0] pId[NREQ];
    bit [4:0] pRd[NREQ], pRs1[NREQ], pRs2[NREQ];

    bit         keepValid, injectMode, forceSpurious;
    logic [2:0] lastReady;
    int         checks = 0;
    int         failures = 0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    task automatic modelReset();
        mq.delete();
        mErr = 0; mNeed = 0; mSimple = 0; mBos = 0; mOp1 = 0; mOp2 = 0;
        mId = 0; mDoneId = 0; mRd = 0; mRs1 = 0; mRs2 = 0; mDone = 0; mNext = 0;
    endtask

    // Requester that would be accepted this cycle, or -1.
    function automatic int modelGrant();
        int start;
        if (!rdy || register_flush || mq.size() >= DEPTH) return -1;
`ifdef RENAME_ARB_RR_EN
        start = mNext;
`else
        start = 0;
`endif
        for (int k = 0; k < NREQ; k++)
            if (pend[(start + k) % NREQ]) return (start + k) % NREQ;
        return -1;
    endfunction

    task automatic modelStep(input int g);
        entry_t h;
        if (!rdy) return;
        if (register_flush) begin
            mNeed = 0; mDone = 0; mq.delete();
            return;
        end
        mDone = 0;
        if (rename_finish || simple_ins_commit) begin
            if (mq.size() == 0) mErr = 1;
            else begin
                h = mq.pop_front();
                if (h.simple ? (simple_ins_commit && !rename_finish) : (rename_finish && !simple_ins_commit)) begin
                    mDone   = 3'(1 << h.owner);
                    mDoneId = rename_finish ? rename_finish_id : h.id;
                end else mErr = 1;
            end
        end else if (mq.size() > 0 && mq[0].age >= 1) begin
            mErr = 1;
            void'(mq.pop_front());
        end
        foreach (mq[k]) mq[k].age++;
        mNeed = (g >= 0);
        if (g >= 0) begin
            mq.push_back('{owner: g, simple: pSimple[g], id: pId[g], age: 0});
            mSimple = pSimple[g]; mBos = pBos[g]; mOp1 = pOp1[g]; mOp2 = pOp2[g];
            mId = pId[g]; mRd = pRd[g]; mRs1 = pRs1[g]; mRs2 = pRs2[g];
            mNext = (g + 1) % NREQ;
        end
    endtask

    // Plays the register file: answers the oldest in-flight rename once it is due.
    task automatic driveResponse();
        rename_finish     = 0;
        simple_ins_commit = 0;
        rename_finish_id  = 4'($urandom_range(0, 15));
        if (mq.size() > 0 && mq[0].age >= 1) begin
            if (mq[0].simple) simple_ins_commit = 1;
            else begin
                rename_finish    = 1;
                rename_finish_id = (injectMode && $urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : mq[0].id;
            end
        end
        if (injectMode && $urandom_range(0, 9) == 0) begin
            case ($urandom_range(0, 2))
                0: {rename_finish, simple_ins_commit} = 2'b00;
                1: {rename_finish, simple_ins_commit} = {simple_ins_commit, rename_finish};
                default: rename_finish = 1;
            endcase
        end
        if (forceSpurious) rename_finish = 1;
    endtask

    task automatic checkRegs();
        checkOutput("rename_need", rename_need, mNeed);
        checkOutput("flags", {rename_need_ins_is_simple, rename_need_ins_is_branch_or_store, operand_1_flag, operand_2_flag},
                    {mSimple, mBos, mOp1, mOp2});
        checkOutput("need_id", {rename_need_id, new_ins_rd_rename}, {mId, mId});
        checkOutput("regs", {new_ins_rd, operand_1_reg, operand_2_reg}, {mRd, mRs1, mRs2});
        checkOutput("done", done, mDone);
        checkOutput("done_id", done_id, mDoneId);
        checkOutput("resp_err", resp_err, mErr);
    endtask

    // One clock cycle; entered and left 1ns after a rising edge.
    task automatic applyStimulus();
        int g;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i] = pend[i]; req_simple[i] = pSimple[i]; req_bos[i] = pBos[i];
            req_op1_flag[i] = pOp1[i]; req_op2_flag[i] = pOp2[i];
            req_id[i*4 +: 4] = pId[i]; req_rd[i*5 +: 5] = pRd[i];
            req_rs1[i*5 +: 5] = pRs1[i]; req_rs2[i*5 +: 5] = pRs2[i];
        end
        driveResponse();
        #4;
        g = modelGrant();
        checkOutput("req_ready", req_ready, (g >= 0) ? (1 << g) : 0);
        lastReady = req_ready;
        @(posedge clk);
        modelStep(g);
        #1;
        checkRegs();
        if (g >= 0 && !keepValid) pend[g] = 0;
    endtask

    task automatic setReq(input int i, input bit s, input bit b, input bit o1, input bit o2,
                          input bit [3:0] id, input bit [4:0] rd, input bit [4:0] rs1, input bit [4:0] rs2);
        pend[i] = 1; pSimple[i] = s; pBos[i] = b; pOp1[i] = o1; pOp2[i] = o2;
        pId[i] = id; pRd[i] = rd; pRs1[i] = rs1; pRs2[i] = rs2;
    endtask

    task automatic randomRequests();
        for (int i = 0; i < NREQ; i++)
            if (!pend[i] && $urandom_range(0, 1) == 1)
                setReq(i, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                       4'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
    endtask

    task automatic doReset();
        rst = 0;
        #1;
        modelReset();
        checkRegs();
        @(posedge clk);
        #1;
        checkRegs();
        rst = 1;
        for (int i = 0; i < NREQ; i++) pend[i] = 0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n, c;
        rst = 1; rdy = 1; register_flush = 0;
        req_valid = 0; req_simple = 0; req_bos = 0; req_op1_flag = 0; req_op2_flag = 0;
        req_id = 0; req_rd = 0; req_rs1 = 0; req_rs2 = 0;
        rename_finish = 0; simple_ins_commit = 0; rename_finish_id = 0;
        keepValid = 0; injectMode = 0; forceSpurious = 0;
        for (int i = 0; i < NREQ; i++) pend[i] = 0;
        #2;
        doReset();

        // Single non-simple request from requester 1, accepted on the first edge out of reset.
        setReq(1, 0, 0, 1, 1, 4'd5, 5'd7, 5'd3, 5'd4);
        applyStimulus();
        checkOutput("single_ready", lastReady, 3'b010);
        checkOutput("single_need", rename_need, 1);
        checkOutput("single_id", rename_need_id, 5);
        checkOutput("single_rd", new_ins_rd, 7);
        applyStimulus();
        applyStimulus();
        checkOutput("single_done", done, 3'b010);
        checkOutput("single_done_id", done_id, 5);
        applyStimulus();

        // Simple instruction completes through simple_ins_commit with its queued id.
        setReq(0, 1, 0, 0, 1, 4'd9, 5'd1, 5'd2, 5'd6);
        applyStimulus();
        checkOutput("simple_flag", rename_need_ins_is_simple, 1);
        applyStimulus();
        applyStimulus();
        checkOutput("simple_done", done, 3'b001);
        checkOutput("simple_done_id", done_id, 9);
        applyStimulus();

        // All three requesters held valid: observe six grants.
        doReset();
        keepValid = 1;
        for (int i = 0; i < NREQ; i++)
            setReq(i, 1'($urandom), 0, 1, 0, 4'(i + 1), 5'(i), 5'(i + 8), 5'(i + 16));
        n = 0; c = 0;
        while (n < 6 && c < 40) begin
            applyStimulus();
            c++;
            if (lastReady != 0) begin
`ifdef RENAME_ARB_RR_EN
                checkOutput("grant_order", lastReady, 1 << (n % 3));
`else
                checkOutput("grant_order", lastReady, 3'b001);
`endif
                n++;
            end
        end
        checkOutput("grant_count", n, 6);
        keepValid = 0;
        for (int i = 0; i < NREQ; i++) pend[i] = 0;
        repeat (4) applyStimulus();

        // Two back-to-back transfers then a flush: nothing completes, no error.
        setReq(0, 0, 1, 1, 1, 4'd3, 5'd10, 5'd11, 5'd12);
        setReq(2, 1, 0, 0, 0, 4'd12, 5'd20, 5'd21, 5'd22);
        applyStimulus();
        checkOutput("b2b_grant0", lastReady != 0, 1);
        applyStimulus();
        checkOutput("b2b_grant1", lastReady != 0, 1);
        register_flush = 1;
        applyStimulus();
        register_flush = 0;
        checkOutput("flush_need", rename_need, 0);
        repeat (4) begin
            applyStimulus();
            checkOutput("flush_done", done, 0);
            checkOutput("flush_err", resp_err, 0);
        end

        // rdy low between issue and response, then a spurious response.
        setReq(1, 0, 1, 0, 1, 4'd6, 5'd9, 5'd8, 5'd7);
        applyStimulus();
        rdy = 0;
        repeat (3) begin
            applyStimulus();
            checkOutput("hold_need", rename_need, 1);
            checkOutput("hold_id", rename_need_id, 6);
        end
        rdy = 1;
        applyStimulus();
        applyStimulus();
        checkOutput("hold_done", done, 3'b010);
        checkOutput("hold_done_id", done_id, 6);
        applyStimulus();
        forceSpurious = 1;
        applyStimulus();
        forceSpurious = 0;
        checkOutput("spurious_err", resp_err, 1);
        repeat (3) begin
            applyStimulus();
            checkOutput("sticky_err", resp_err, 1);
        end
        doReset();
        checkOutput("err_cleared", resp_err, 0);

        // Random traffic with rdy stalls and flushes, a mid-run reset, then protocol faults.
        for (int k = 0; k < 500; k++) begin
            if (k == 250) doReset();
            if (k == 350) injectMode = 1;
            randomRequests();
            rdy = ($urandom_range(0, 4) != 0);
            register_flush = ($urandom_range(0, 24) == 0);
            applyStimulus();
        end
        injectMode = 0; rdy = 1; register_flush = 0;
        repeat (4) applyStimulus();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
